pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 237 +++++++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Parametrised pipeline stage register with a valid/ready handshake. It
//   replaces the hand-written inter-stage registers (IF/ID, ID/EX, EX/MEM,
//   MEM/WB). It holds a main slot, which drives out_*, and a skid slot. Because
//   the skid slot absorbs the beat in flight, in_ready can be a pure register.
//   A synchronous flush empties the stage and turns its output into a bubble.
//   On a bubble the control field is forced to zero, so downstream write
//   enables stay low.
//
// Optional feature
//   Define the macro PIPE_STAGE_REG_PERF_EN to build saturating performance
//   counters. If the macro is not defined, the perf ports stay in the port list
//   and are tied to zero.
//
// Parameters
//   CTRL_W  width of the control field (zeroed on bubbles)
//   DATA_W  width of the data field (holds its last value on bubbles)
//   PERF_W  width of each performance counter
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_valid     upstream beat present
//   in_ready     stage can accept a beat (registered)
//   in_ctrl      upstream control field
//   in_data      upstream data field
//   flush        discard all held and incoming beats this cycle
//   out_valid    downstream beat present (registered)
//   out_ready    downstream accepts the beat
//   out_ctrl     control field, 0 whenever out_valid = 0
//   out_data     data field, holds its last value when out_valid = 0
//   occupancy    number of beats held: 0, 1 or 2 (registered)
//   perf_stall   cycles with out_valid = 1 and out_ready = 0
//   perf_bubble  cycles with out_valid = 0 (reset cycles excluded)
//   perf_flush   number of flush cycles
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int CTRL_W = 10,
    parameter int DATA_W = 138,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_bubble,
    output logic [PERF_W-1:0] perf_flush
);

    // The state encoding is {main_valid, skid_valid}. 2'b01 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                in_ready_r;
    logic [1:0]          occupancy_r;
    logic [CTRL_W-1:0]   main_ctrl_r;
    logic [DATA_W-1:0]   main_data_r;
    logic [CTRL_W-1:0]   skid_ctrl_r;
    logic [DATA_W-1:0]   skid_data_r;

    logic                acc_s;
    logic                pop_s;
    logic                load_main_in_s;
    logic                load_main_skid_s;
    logic                load_skid_s;
    logic                main_valid_s;
    logic                skid_valid_s;

    // Handshake qualifiers. Both depend only on registers and the partner's valid/ready.
    always_comb begin
        acc_s = in_valid & in_ready_r;
        pop_s = state_r[1] & out_ready;
    end

    // Next-state and slot-load selection. Flush overrides every transition.
    always_comb begin
        state_s          = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (acc_s) begin
                    state_s        = ST_ONE;
                    load_main_in_s = 1'b1;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (acc_s && pop_s) begin
                    state_s        = ST_ONE;
                    load_main_in_s = 1'b1;
                end else if (acc_s) begin
                    // The main slot is still occupied, so the new beat waits behind it.
                    state_s     = ST_FULL;
                    load_skid_s = 1'b1;
                end else if (pop_s) begin
                    state_s = ST_EMPTY;
                end else begin
                    state_s = ST_ONE;
                end
            end
            ST_FULL: begin
                if (pop_s) begin
                    state_s          = ST_ONE;
                    load_main_skid_s = 1'b1;
                end else begin
                    state_s = ST_FULL;
                end
            end
            default: begin
                state_s = ST_EMPTY;
            end
        endcase
        if (flush) begin
            // A beat accepted in this cycle is dropped, and a pop still completes downstream.
            state_s          = ST_EMPTY;
            load_main_in_s   = 1'b0;
            load_main_skid_s = 1'b0;
            load_skid_s      = 1'b0;
        end else begin
            state_s = state_s;
        end
    end

    // Slot valids that follow from the next state.
    always_comb begin
        main_valid_s = state_s[1];
        skid_valid_s = state_s[0];
    end

    // State, in_ready and occupancy registers. in_ready stays low while reset is asserted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b0;
            occupancy_r <= 2'b00;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= ~skid_valid_s;
            occupancy_r <= {1'b0, main_valid_s} + {1'b0, skid_valid_s};
        end
    end

    // Main slot. The control field is cleared whenever the slot becomes a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_ctrl_r <= {CTRL_W{1'b0}};
            main_data_r <= {DATA_W{1'b0}};
        end else if (load_main_in_s) begin
            main_ctrl_r <= in_ctrl;
            main_data_r <= in_data;
        end else if (load_main_skid_s) begin
            main_ctrl_r <= skid_ctrl_r;
            main_data_r <= skid_data_r;
        end else if (!main_valid_s) begin
            main_ctrl_r <= {CTRL_W{1'b0}};
            main_data_r <= main_data_r;
        end else begin
            main_ctrl_r <= main_ctrl_r;
            main_data_r <= main_data_r;
        end
    end

    // Skid slot. It captures the beat that is accepted while the main slot stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            skid_ctrl_r <= {CTRL_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
        end else if (load_skid_s) begin
            skid_ctrl_r <= in_ctrl;
            skid_data_r <= in_data;
        end else begin
            skid_ctrl_r <= skid_ctrl_r;
            skid_data_r <= skid_data_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = state_r[1];
    assign out_ctrl  = main_ctrl_r;
    assign out_data  = main_data_r;
    assign occupancy = occupancy_r;

`ifdef PIPE_STAGE_REG_PERF_EN
    logic [PERF_W-1:0] perf_stall_r;
    logic [PERF_W-1:0] perf_bubble_r;
    logic [PERF_W-1:0] perf_flush_r;

    // Saturating increment. The value sticks at all-ones.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        if (v == {PERF_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(PERF_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Performance counters. Only reset clears them, and reset cycles are not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_r  <= {PERF_W{1'b0}};
            perf_bubble_r <= {PERF_W{1'b0}};
            perf_flush_r  <= {PERF_W{1'b0}};
        end else begin
            perf_stall_r  <= (state_r[1] && !out_ready) ? sat_inc(perf_stall_r) : perf_stall_r;
            perf_bubble_r <= (!state_r[1]) ? sat_inc(perf_bubble_r) : perf_bubble_r;
            perf_flush_r  <= flush ? sat_inc(perf_flush_r) : perf_flush_r;
        end
    end

    assign perf_stall  = perf_stall_r;
    assign perf_bubble = perf_bubble_r;
    assign perf_flush  = perf_flush_r;
`else
    assign perf_stall  = {PERF_W{1'b0}};
    assign perf_bubble = {PERF_W{1'b0}};
    assign perf_flush  = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Directed self-checking bench for pipe_stage_reg. Inputs change #1 after the
//   rising edge. Outputs are checked after that edge, once the registers have
//   settled.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int CTRL_W = 10;
    localparam int DATA_W = 138;
    localparam int PERF_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [PERF_W-1:0] perf_stall;
    logic [PERF_W-1:0] perf_bubble;
    logic [PERF_W-1:0] perf_flush;

    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .PERF_W(PERF_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy),
        .perf_stall(perf_stall), .perf_bubble(perf_bubble), .perf_flush(perf_flush)
    );

    // Free-running clock with a 10 ns period.
    always #5 clk = ~clk;

    // Single comparison point. Every check counts here.
    task automatic check_eq(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        in_valid = 1'b1;
        in_ctrl  = CTRL_W'(v);
        in_data  = DATA_W'(v);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        flush = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        // Values while reset is held.
        check_eq("rst_out_valid", 160'(out_valid), 160'(1'b0));
        check_eq("rst_out_ctrl",  160'(out_ctrl), 160'(0));
        check_eq("rst_out_data",  160'(out_data), 160'(0));
        check_eq("rst_in_ready",  160'(in_ready), 160'(1'b0));
        check_eq("rst_occupancy", 160'(occupancy), 160'(0));
        check_eq("rst_perf_stall",  160'(perf_stall), 160'(0));
        check_eq("rst_perf_bubble", 160'(perf_bubble), 160'(0));
        check_eq("rst_perf_flush",  160'(perf_flush), 160'(0));

        reset = 1'b0;
        tick();
        check_eq("post_rst_in_ready", 160'(in_ready), 160'(1'b1));

        // Single beat with 1-cycle latency, followed by a bubble that zeroes ctrl.
        in_valid = 1'b1; in_ctrl = 10'h2A5; in_data = DATA_W'(16'h1234); out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("single_valid", 160'(out_valid), 160'(1'b1));
        check_eq("single_ctrl",  160'(out_ctrl), 160'(10'h2A5));
        check_eq("single_data",  160'(out_data), 160'(16'h1234));
        tick();
        check_eq("single_after_valid", 160'(out_valid), 160'(1'b0));
        check_eq("single_after_ctrl",  160'(out_ctrl), 160'(0));
        check_eq("single_after_data_hold", 160'(out_data), 160'(16'h1234));
        check_eq("single_after_occ",   160'(occupancy), 160'(0));

        // Stream of beats 1..8 at full throughput.
        for (int i = 1; i <= 8; i++) begin
            push(i);
            tick();
            check_eq($sformatf("stream_data_%0d", i), 160'(out_data), 160'(i));
            check_eq($sformatf("stream_valid_%0d", i), 160'(out_valid), 160'(1'b1));
            check_eq($sformatf("stream_in_ready_%0d", i), 160'(in_ready), 160'(1'b1));
        end
        in_valid = 1'b0;
        tick();
        check_eq("stream_drain_valid", 160'(out_valid), 160'(1'b0));

        // Backpressure: A and B are held, and C waits upstream.
        out_ready = 1'b0;
        push(32'hA);
        tick();
        check_eq("bp_occ_a", 160'(occupancy), 160'(1));
        check_eq("bp_rdy_a", 160'(in_ready), 160'(1'b1));
        push(32'hB);
        tick();
        check_eq("bp_occ_b",  160'(occupancy), 160'(2));
        check_eq("bp_rdy_b",  160'(in_ready), 160'(1'b0));
        check_eq("bp_data_b", 160'(out_data), 160'(32'hA));
        push(32'hC);
        tick();
        check_eq("bp_occ_c_held",  160'(occupancy), 160'(2));
        check_eq("bp_data_c_held", 160'(out_data), 160'(32'hA));
        out_ready = 1'b1;
        tick();
        check_eq("bp_out_b",   160'(out_data), 160'(32'hB));
        check_eq("bp_rdy_up",  160'(in_ready), 160'(1'b1));
        check_eq("bp_occ_one", 160'(occupancy), 160'(1));
        tick();
        in_valid = 1'b0;
        check_eq("bp_out_c",       160'(out_data), 160'(32'hC));
        check_eq("bp_out_c_valid", 160'(out_valid), 160'(1'b1));
        tick();
        check_eq("bp_end_valid", 160'(out_valid), 160'(1'b0));
        check_eq("bp_end_occ",   160'(occupancy), 160'(0));

        // Flush with the stage full and beat D being offered.
        out_ready = 1'b0;
        push(32'hE); tick();
        push(32'hF); tick();
        check_eq("fl_occ_pre", 160'(occupancy), 160'(2));
        push(32'hD); flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check_eq("fl_valid", 160'(out_valid), 160'(1'b0));
        check_eq("fl_ctrl",  160'(out_ctrl), 160'(0));
        check_eq("fl_occ",   160'(occupancy), 160'(0));
        check_eq("fl_rdy",   160'(in_ready), 160'(1'b1));
        tick();
        check_eq("fl_no_d_valid", 160'(out_valid), 160'(1'b0));
        check_eq("fl_no_d_occ",   160'(occupancy), 160'(0));

        // Reset while the stage holds two beats.
        out_ready = 1'b0;
        push(32'h11); tick();
        push(32'h22); tick();
        check_eq("rm_occ_pre", 160'(occupancy), 160'(2));
        in_valid = 1'b0; reset = 1'b1;
        tick();
        check_eq("rm_valid", 160'(out_valid), 160'(1'b0));
        check_eq("rm_rdy",   160'(in_ready), 160'(1'b0));
        check_eq("rm_occ",   160'(occupancy), 160'(0));
        check_eq("rm_ctrl",  160'(out_ctrl), 160'(0));
        reset = 1'b0;
        tick();
        check_eq("rm_rdy_after", 160'(in_ready), 160'(1'b1));

        // Performance counters: 3 bubble cycles, 5 stall cycles and 2 flush cycles after reset.
        reset = 1'b1; tick();
        reset = 1'b0; push(32'h55); out_ready = 1'b0;
        tick();              // in_ready is still low, so this is bubble 1
        tick();              // beat accepted, bubble 2
        in_valid = 1'b0;
        repeat (5) tick();   // stalls 1..5
        flush = 1'b1; out_ready = 1'b1;
        tick();              // flush 1, and the beat pops
        out_ready = 1'b0;
        tick();              // flush 2, bubble 3
        flush = 1'b0;
`ifdef PIPE_STAGE_REG_PERF_EN
        check_eq("perf_stall",  160'(perf_stall), 160'(5));
        check_eq("perf_bubble", 160'(perf_bubble), 160'(3));
        check_eq("perf_flush",  160'(perf_flush), 160'(2));
`else
        check_eq("perf_stall",  160'(perf_stall), 160'(0));
        check_eq("perf_bubble", 160'(perf_bubble), 160'(0));
        check_eq("perf_flush",  160'(perf_flush), 160'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
